// File: rtl/id_stage_param_if.sv
// Bundle between the IF/ID register, the EX/MEM and MEM/WB feedback paths and the
// id_stage_param decode stage. The decode stage uses the slave modport.
interface id_stage_param_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(NREGS);

  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc_plus4;
  logic            exmem_reg_write;
  logic            exmem_mem_read;
  logic [AW-1:0]   exmem_dst;
  logic [XLEN-1:0] exmem_alu_result;
  logic            memwb_reg_write;
  logic [AW-1:0]   memwb_dst;
  logic [XLEN-1:0] memwb_write_data;
  logic            stall;
  logic            flush;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            idex_valid;
  logic            idex_reg_write;
  logic            idex_mem_to_reg;
  logic            idex_mem_read;
  logic            idex_mem_write;
  logic            idex_alu_src;
  logic            idex_reg_dst;
  logic [1:0]      idex_alu_op;
  logic [XLEN-1:0] idex_rdata1;
  logic [XLEN-1:0] idex_rdata2;
  logic [XLEN-1:0] idex_imm;
  logic [AW-1:0]   idex_rs;
  logic [AW-1:0]   idex_rt;
  logic [AW-1:0]   idex_rd;
  logic [CNT_W-1:0] stall_count;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport slave (
    input  if_valid, if_instr, if_pc_plus4,
    input  exmem_reg_write, exmem_mem_read, exmem_dst, exmem_alu_result,
    input  memwb_reg_write, memwb_dst, memwb_write_data, dbg_addr,
    output stall, flush, redirect, redirect_target,
    output idex_valid, idex_reg_write, idex_mem_to_reg, idex_mem_read,
    output idex_mem_write, idex_alu_src, idex_reg_dst, idex_alu_op,
    output idex_rdata1, idex_rdata2, idex_imm, idex_rs, idex_rt, idex_rd,
    output stall_count, dbg_data
  );

  modport master (
    output if_valid, if_instr, if_pc_plus4,
    output exmem_reg_write, exmem_mem_read, exmem_dst, exmem_alu_result,
    output memwb_reg_write, memwb_dst, memwb_write_data, dbg_addr,
    input  stall, flush, redirect, redirect_target,
    input  idex_valid, idex_reg_write, idex_mem_to_reg, idex_mem_read,
    input  idex_mem_write, idex_alu_src, idex_reg_dst, idex_alu_op,
    input  idex_rdata1, idex_rdata2, idex_imm, idex_rs, idex_rt, idex_rd,
    input  stall_count, dbg_data
  );
endinterface

// File: rtl/id_stage_param.sv
// Decode stage with register file, hazard detection, early branch resolution and ID/EX register.
// Optional feature: define ID_BNE_EN to decode opcode 0x05 as bne.
module id_stage_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input logic            clock,
  input logic            reset,
  id_stage_param_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [XLEN-1:0] regs [NREGS];

  ctrl_t           dec;
  logic            is_beq, is_bne, is_jump, uses_rt, is_branch;
  logic [AW-1:0]   rs, rt, rd, idex_dst;
  logic [XLEN-1:0] imm_sext, rf_rs, rf_rt, cmp_a, cmp_b;
  logic [XLEN-1:0] br_target, j_target;
  logic            wb_en, br_taken;
  logic            haz_load_use, haz_br_alu, haz_br_load, stall_int;

  assign rs       = AW'(bus.if_instr[25:21]);
  assign rt       = AW'(bus.if_instr[20:16]);
  assign rd       = AW'(bus.if_instr[15:11]);
  assign imm_sext = {{(XLEN-16){bus.if_instr[15]}}, bus.if_instr[15:0]};

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    dec     = '0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jump = 1'b0;
    uses_rt = 1'b0;
    if (bus.if_valid) begin
      case (opcode_e'(bus.if_instr[31:26]))
        OP_RTYPE: begin
          dec.reg_dst   = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = 2'b10;
          uses_rt       = 1'b1;
        end
        OP_LW: begin
          dec.alu_src    = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.reg_write  = 1'b1;
          dec.mem_read   = 1'b1;
        end
        OP_SW: begin
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          uses_rt       = 1'b1;
        end
        OP_BEQ: begin
          dec.alu_op = 2'b01;
          is_beq     = 1'b1;
          uses_rt    = 1'b1;
        end
`ifdef ID_BNE_EN
        OP_BNE: begin
          dec.alu_op = 2'b01;
          is_bne     = 1'b1;
          uses_rt    = 1'b1;
        end
`endif
        OP_J: is_jump = 1'b1;
        default: ;
      endcase
    end
  end

  assign is_branch = is_beq | is_bne;

  // Register file reads see a same-cycle WB write (write-through).
  assign wb_en = bus.memwb_reg_write && (bus.memwb_dst != '0);
  assign rf_rs = (rs == '0) ? '0 : (wb_en && bus.memwb_dst == rs) ? bus.memwb_write_data : regs[rs];
  assign rf_rt = (rt == '0) ? '0 : (wb_en && bus.memwb_dst == rt) ? bus.memwb_write_data : regs[rt];

  // Comparator operands prefer a completed ALU result sitting in EX/MEM.
  assign cmp_a = (bus.exmem_reg_write && !bus.exmem_mem_read && bus.exmem_dst != '0 &&
                  bus.exmem_dst == rs) ? bus.exmem_alu_result : rf_rs;
  assign cmp_b = (bus.exmem_reg_write && !bus.exmem_mem_read && bus.exmem_dst != '0 &&
                  bus.exmem_dst == rt) ? bus.exmem_alu_result : rf_rt;

  assign br_taken = (is_beq && (cmp_a == cmp_b)) || (is_bne && (cmp_a != cmp_b));

  assign idex_dst     = bus.idex_reg_dst ? bus.idex_rd : bus.idex_rt;
  assign haz_load_use = bus.idex_mem_read && (bus.idex_rt != '0) &&
                        ((bus.idex_rt == rs) || (uses_rt && bus.idex_rt == rt));
  assign haz_br_alu   = is_branch && bus.idex_reg_write && (idex_dst != '0) &&
                        ((idex_dst == rs) || (idex_dst == rt));
  assign haz_br_load  = is_branch && bus.exmem_mem_read && (bus.exmem_dst != '0) &&
                        ((bus.exmem_dst == rs) || (bus.exmem_dst == rt));
  assign stall_int    = !reset && bus.if_valid && (haz_load_use || haz_br_alu || haz_br_load);

  assign br_target = bus.if_pc_plus4 + (imm_sext << 2);
  assign j_target  = {bus.if_pc_plus4[XLEN-1:28], bus.if_instr[25:0], 2'b00};

  assign bus.stall           = stall_int;
  assign bus.redirect        = !reset && !stall_int && (br_taken || is_jump);
  assign bus.flush           = bus.redirect;
  assign bus.redirect_target = is_jump ? j_target : br_target;
  assign bus.dbg_data        = (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];

  // NOTE: the register array is reset explicitly because it must read back as zero after reset,
  // which rules out a plain RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[bus.memwb_dst] <= bus.memwb_write_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.idex_valid      <= 1'b0;
      bus.idex_reg_write  <= 1'b0;
      bus.idex_mem_to_reg <= 1'b0;
      bus.idex_mem_read   <= 1'b0;
      bus.idex_mem_write  <= 1'b0;
      bus.idex_alu_src    <= 1'b0;
      bus.idex_reg_dst    <= 1'b0;
      bus.idex_alu_op     <= '0;
      bus.idex_rdata1     <= '0;
      bus.idex_rdata2     <= '0;
      bus.idex_imm        <= '0;
      bus.idex_rs         <= '0;
      bus.idex_rt         <= '0;
      bus.idex_rd         <= '0;
      bus.stall_count     <= '0;
    end else begin
      bus.idex_rdata1 <= rf_rs;
      bus.idex_rdata2 <= rf_rt;
      bus.idex_imm    <= imm_sext;
      bus.idex_rs     <= rs;
      bus.idex_rt     <= rt;
      bus.idex_rd     <= rd;
      if (stall_int) begin
        bus.idex_valid      <= 1'b0;
        bus.idex_reg_write  <= 1'b0;
        bus.idex_mem_to_reg <= 1'b0;
        bus.idex_mem_read   <= 1'b0;
        bus.idex_mem_write  <= 1'b0;
        bus.idex_alu_src    <= 1'b0;
        bus.idex_reg_dst    <= 1'b0;
        bus.idex_alu_op     <= '0;
        if (bus.stall_count != '1) bus.stall_count <= bus.stall_count + 1'b1;
      end else begin
        bus.idex_valid      <= bus.if_valid;
        bus.idex_reg_write  <= dec.reg_write;
        bus.idex_mem_to_reg <= dec.mem_to_reg;
        bus.idex_mem_read   <= dec.mem_read;
        bus.idex_mem_write  <= dec.mem_write;
        bus.idex_alu_src    <= dec.alu_src;
        bus.idex_reg_dst    <= dec.reg_dst;
        bus.idex_alu_op     <= dec.alu_op;
      end
    end
  end
endmodule

// File: doc/id_stage_param.md
# id_stage_param

Parametrised decode stage with an integrated ID/EX pipeline register, register file, hazard detection and early branch resolution. It sits between the IF/ID register and the EX stage of the 5-stage pipeline. It generates its own stall, flush and redirect controls and no longer depends on an external hazard unit. It adds reset, a valid bit, a branch-hazard stall, MEM/WB forwarding into the comparator, and a stall counter.

## Interface
Parameters:
- XLEN, 32, datapath width (must be ≥ 32)
- NREGS, 32, number of architectural registers (power of 2); AW = $clog2(NREGS)
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_valid  in  1  IF/ID holds a real instruction
- if_instr  in  32  IF/ID instruction
- if_pc_plus4  in  XLEN  IF/ID PC+4
- exmem_reg_write, exmem_mem_read  in  1  EX/MEM controls
- exmem_dst  in  AW  EX/MEM destination register
- exmem_alu_result  in  XLEN  EX/MEM ALU result
- memwb_reg_write  in  1  WB write enable
- memwb_dst  in  AW  WB destination register
- memwb_write_data  in  XLEN  WB data
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  zero IF/ID at next edge
- redirect  out  1  PC takes redirect_target
- redirect_target  out  XLEN  branch or jump target
- idex_valid, idex_reg_write, idex_mem_to_reg, idex_mem_read, idex_mem_write, idex_alu_src, idex_reg_dst  out  1  ID/EX controls
- idex_alu_op  out  2  ID/EX ALU op
- idex_rdata1, idex_rdata2, idex_imm  out  XLEN  ID/EX operands and sign-extended immediate
- idex_rs, idex_rt, idex_rd  out  AW  ID/EX register fields (rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], truncated to AW)
- stall_count  out  CNT_W  saturating count of stall cycles
- dbg_addr  in  AW, dbg_data  out  XLEN  combinational register file peek

## Operation
- Decode by opcode:
  - R-type 0x00: RegDst, RegWrite, ALUOp = 10
  - lw 0x23: ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp = 00
  - sw 0x2B: ALUSrc, MemWrite, ALUOp = 00
  - beq 0x04: branch, ALUOp = 01
  - j 0x02: jump
  - Any other opcode, or if_valid = 0: all controls 0, no branch, no jump.
- uses_rt = R-type | sw | beq (| bne, see Configuration).
- Register file:
  - NREGS × XLEN, written at the clock edge when memwb_reg_write is high and memwb_dst ≠ 0.
  - Register 0 always reads 0.
  - Reads are combinational with write-through: a same-cycle WB to the register being read returns memwb_write_data.
- Comparator operand priority per operand:
  - EX/MEM result when exmem_reg_write, !exmem_mem_read and exmem_dst == src ≠ 0.
  - Otherwise the register file value, which includes the WB write-through.
- Hazards:
  - Load-use: idex_mem_read and the ID/EX destination (idex_rt) ≠ 0 and equals rs, or equals rt with uses_rt.
  - Branch-ALU: branch in ID and idex_reg_write and the ID/EX destination (idex_reg_dst ? idex_rd : idex_rt) ≠ 0 and matches rs or rt.
  - Branch-load: branch in ID and exmem_mem_read and exmem_dst ≠ 0 and matches rs or rt.
- stall is 1 when if_valid and any of the three hazards holds.
  - On stall: ID/EX loads a bubble (valid and all controls 0; data fields don't-care).
  - On stall: redirect = 0 and flush = 0.
- Taken redirect (not stalled):
  - Taken branch: redirect = 1, flush = 1, target = if_pc_plus4 + (sext(imm16) << 2), modulo 2^XLEN.
  - Jump: redirect = 1, flush = 1, target = {if_pc_plus4[XLEN-1:28], instr[25:0], 2'b00}.
  - A taken branch still issues a bubble-free ID/EX entry with controls 0.
- Otherwise ID/EX captures the decoded controls, operands, imm and fields, and idex_valid = if_valid.
- stall_count increments on each stall cycle and saturates at 2^CNT_W−1.

## Timing
- ID/EX outputs are registered with 1-cycle latency.
- stall, flush, redirect and redirect_target are combinational in the same cycle.
- Branch dependent on an ALU op directly ahead: 1 stall cycle, then resolves using EX/MEM forwarding.
- Branch dependent on a load directly ahead: 2 stall cycles (branch-ALU, then branch-load), then resolves via WB write-through.
- Load-use: 1 stall cycle.
- Reset (any cycle, overrides everything):
  - All idex_* outputs become 0 and stall_count becomes 0.
  - All registers clear to 0; a WB write in the same cycle is dropped.
- While reset is high, stall, flush and redirect are forced to 0.

## Configuration
- ID_BNE_EN defined: opcode 0x05 decodes as bne (ALUOp = 01, uses_rt). It is taken when the operands differ and gets the same hazard and stall treatment as beq.
- ID_BNE_EN undefined: opcode 0x05 is an unknown opcode (all controls 0).

## Test plan
- Reset pulse with prior garbage → all idex_* outputs, stall_count and dbg_data(any) read 0 on the cycle after reset.
- WB writes r5 = 0x1234 while ID reads add r1,r5,r5 → idex_rdata1 = idex_rdata2 = 0x1234 next cycle; a WB write to r0 leaves r0 = 0.
- lw r2,0(r3) followed by add r4,r2,r2 → stall = 1 for exactly 1 cycle, bubble in ID/EX, stall_count = 1.
- add r2,r1,r1 (r1 = 3) then beq r2,r6 with r6 = 6 at PC+4 = 0x100, imm = 4 → 1 stall, then redirect = 1, target = 0x110, flush = 1.
- lw r2 then beq r2,r0 → 2 stall cycles before resolution; j 0x0000040 at PC+4 = 0x10000004 → target = 0x10000100, flush = 1.
- With ID_BNE_EN: bne r1,r1 → not taken, no redirect; without it, opcode 0x05 → all idex controls 0.
